exp_align_mantissa: RTL and testbench
=====================================

Name: exp_align_mantissa

Overview:
- Pipelined mantissa-alignment stage directly downstream of the exponent-difference unit in the FP add/sub datapath.
- Consumes the greater exponent, the exponent difference and the swap flag from that unit, plus the two raw mantissas (hidden bit already attached).
- Routes the mantissa of the larger-exponent operand through unchanged and right-shifts the other by the difference, producing guard, round and sticky bits.
- Two-stage pipeline with valid/ready backpressure on both sides.

Parameters:
- SIZE_EXP, 8, exponent width; width of the difference and exponent inputs.
- SIZE_MAN, 24, mantissa width including hidden bit.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream data valid.
- o_ready  out  1  this stage can accept data.
- i_man_a  in  SIZE_MAN  mantissa of operand A.
- i_man_b  in  SIZE_MAN  mantissa of operand B.
- i_exp_greater  in  SIZE_EXP  larger exponent from the exponent-difference unit.
- i_diff_value  in  SIZE_EXP  larger minus smaller exponent, unsigned.
- i_diff_signal  in  1  0: exp_a >= exp_b; 1: exp_a < exp_b.
- o_valid  out  1  output data valid.
- i_ready  in  1  downstream can accept.
- o_exp  out  SIZE_EXP  registered i_exp_greater.
- o_swap  out  1  registered i_diff_signal.
- o_man_large  out  SIZE_MAN  mantissa of the larger-exponent operand.
- o_man_small  out  SIZE_MAN+3  aligned smaller mantissa, laid out as {mantissa[SIZE_MAN-1:0], guard, round, sticky}.

Behaviour:
- Reset (async, i_rst_n=0): all valid flags and all data registers are 0, so o_valid=0 and every data output is 0. o_ready rises in the first cycle after reset is released.
- Stage 1 (S1) captures on i_valid & o_ready:
  - i_diff_signal=0: large=i_man_a, small=i_man_b.
  - i_diff_signal=1: large=i_man_b, small=i_man_a.
  - Also captures the exponent, the difference and the swap flag.
- Stage 2 (S2) computes the shift from S1 contents and registers it into the output registers:
  - Form ext = {small, 2'b00} (SIZE_MAN+2 bits).
  - Shift ext right by d, giving aligned[SIZE_MAN+2:1].
  - sticky = OR of every bit of ext shifted below position 0.
  - If d >= SIZE_MAN+2: aligned field = 0 and sticky = OR(small).
  - d=0: o_man_small = {small, 3'b000}.
  - The shift uses the full SIZE_EXP-bit d. No truncation of d before the saturation compare.
- Latency: 2 cycles from accepted input to o_valid when i_ready stays high. Throughput is 1 per cycle.
- Handshake:
  - Transfer out occurs on o_valid & i_ready.
  - S2 loads when S2 is empty or transferring out.
  - S1 advances into S2 under the same condition.
  - o_ready = ~s1_valid | s1_advance.
  - While o_valid=1 and i_ready=0, every output stays stable.
  - o_valid never drops without a transfer.
  - Input is ignored when o_ready=0.
- Simultaneous accept and drain: when S1 advances and a new input is accepted in the same cycle, both take effect. No bubble and no loss.
- Full stall: both stages hold, o_ready=0, and no data is overwritten.
- Reset mid-operation: in-flight data is discarded, valids clear immediately (asynchronously) and no output transfer occurs.
- No combinational path from i_valid to o_valid. o_ready depends combinationally on i_ready only.

Test Plan:
- Reset with i_valid=1 held → o_valid=0 and all outputs 0 during reset. First accepted beat emerges exactly 2 cycles after its handshake.
- Shift 1 (SIZE_MAN=24): man_a=0xC00000, man_b=0x800001, diff=1, diff_signal=0 → o_man_large=0xC00000, o_man_small=0x2000004 (guard=1).
- Shift 2 and 3, same mantissas:
  - diff=2 → o_man_small=0x1000002 (round=1).
  - diff=3 → o_man_small=0x0800001 (sticky=1).
  - diff_signal=1 with diff=3 → o_man_large=0x800001, o_man_small built from 0xC00000 = 0x0C00000, o_swap=1.
- Saturation: diff=30 and diff=255 with small=0x800001 → o_man_small=0x0000001. With small=0 → 0x0000000. diff=0 → o_man_small=small<<3.
- Backpressure: stream 6 beats with i_ready toggled randomly, including 4 consecutive low cycles → all 6 beats arrive in order and unduplicated, outputs are stable while stalled, and o_ready=0 while both stages are full.
- Assert reset while 2 beats are in flight → o_valid drops at once. After release, a fresh beat emerges after 2 cycles with no stale data.

Source files
------------

// File: rtl/exp_align_mantissa.sv
// FP add/sub mantissa alignment: routes the larger-exponent mantissa through
// and right-shifts the other by the exponent difference, with guard/round/sticky.
module exp_align_mantissa #(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 24
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SIZE_MAN-1:0] i_man_a,
    input  logic [SIZE_MAN-1:0] i_man_b,
    input  logic [SIZE_EXP-1:0] i_exp_greater,
    input  logic [SIZE_EXP-1:0] i_diff_value,
    input  logic                i_diff_signal,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SIZE_EXP-1:0] o_exp,
    output logic                o_swap,
    output logic [SIZE_MAN-1:0] o_man_large,
    output logic [SIZE_MAN+2:0] o_man_small
);

    localparam int W_EXT = SIZE_MAN + 2;

    logic                ready_en;
    logic                s1_valid;
    logic [SIZE_MAN-1:0] s1_large;
    logic [SIZE_MAN-1:0] s1_small;
    logic [SIZE_EXP-1:0] s1_exp;
    logic [SIZE_EXP-1:0] s1_diff;
    logic                s1_swap;

    logic                s2_valid;
    logic [SIZE_EXP-1:0] s2_exp;
    logic                s2_swap;
    logic [SIZE_MAN-1:0] s2_large;
    logic [SIZE_MAN+2:0] s2_small;

    logic                s2_load;
    logic                s1_advance;
    logic                in_accept;

    logic [W_EXT-1:0]    ext;
    logic [W_EXT-1:0]    shifted;
    logic                sticky;
    logic                sat;
    logic [31:0]         d_wide;
    logic [SIZE_MAN+2:0] small_aligned;

    assign s2_load    = ~s2_valid | i_ready;
    assign s1_advance = s1_valid & s2_load;
    assign o_ready    = ready_en & (~s1_valid | s1_advance);
    assign in_accept  = i_valid & o_ready;

    // Holds o_ready low until the first clock edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_large <= '0;
            s1_small <= '0;
            s1_exp   <= '0;
            s1_diff  <= '0;
            s1_swap  <= 1'b0;
        end else begin
            if (o_ready) begin
                s1_valid <= i_valid;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
            if (in_accept) begin
                s1_large <= i_diff_signal ? i_man_b : i_man_a;
                s1_small <= i_diff_signal ? i_man_a : i_man_b;
                s1_exp   <= i_exp_greater;
                s1_diff  <= i_diff_value;
                s1_swap  <= i_diff_signal;
            end
        end
    end

    // Full-width difference drives the saturation compare; no truncation.
    always_comb begin
        ext     = {s1_small, 2'b00};
        d_wide  = 32'(s1_diff);
        sat     = d_wide >= 32'(W_EXT);
        shifted = '0;
        sticky  = 1'b0;
        if (sat) begin
            shifted = '0;
            sticky  = |s1_small;
        end else begin
            shifted = ext >> s1_diff;
            sticky  = |(ext & ~({W_EXT{1'b1}} << s1_diff));
        end
        small_aligned = {shifted, sticky};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            s2_exp   <= '0;
            s2_swap  <= 1'b0;
            s2_large <= '0;
            s2_small <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_exp   <= s1_exp;
                s2_swap  <= s1_swap;
                s2_large <= s1_large;
                s2_small <= small_aligned;
            end
        end
    end

    assign o_valid     = s2_valid;
    assign o_exp       = s2_exp;
    assign o_swap      = s2_swap;
    assign o_man_large = s2_large;
    assign o_man_small = s2_small;

endmodule

// File: tb/tb_exp_align_mantissa.sv
// Directed bench for exp_align_mantissa: alignment vectors, latency,
// backpressure with stall stability, and mid-flight reset.
module tb_exp_align_mantissa;

    localparam int EW = 8;
    localparam int MW = 24;

    typedef struct packed {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [EW-1:0] e;
        logic [EW-1:0] d;
        logic          s;
        logic [MW-1:0] xl;
        logic [MW+2:0] xs;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [MW-1:0] i_man_a;
    logic [MW-1:0] i_man_b;
    logic [EW-1:0] i_exp_greater;
    logic [EW-1:0] i_diff_value;
    logic          i_diff_signal;
    logic          o_valid;
    logic          i_ready;
    logic [EW-1:0] o_exp;
    logic          o_swap;
    logic [MW-1:0] o_man_large;
    logic [MW+2:0] o_man_small;

    int            n_vec = 0;
    int            n_err = 0;
    beat_t         q[$];
    beat_t         tbl[10];
    beat_t         idle;
    logic          last_ov;
    logic          acc;
    logic          hold;
    logic [EW-1:0] h_exp;
    logic          h_swap;
    logic [MW-1:0] h_large;
    logic [MW+2:0] h_small;
    int            idx;
    logic          rdy;

    exp_align_mantissa #(.SIZE_EXP(EW), .SIZE_MAN(MW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_man_a       (i_man_a),
        .i_man_b       (i_man_b),
        .i_exp_greater (i_exp_greater),
        .i_diff_value  (i_diff_value),
        .i_diff_signal (i_diff_signal),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_exp         (o_exp),
        .o_swap        (o_swap),
        .o_man_large   (o_man_large),
        .o_man_small   (o_man_small)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One cycle: drive after posedge, observe at negedge, return at posedge+1.
    task automatic step(input logic v, input beat_t bt, input logic r);
        beat_t x;
        i_valid       = v;
        i_man_a       = bt.a;
        i_man_b       = bt.b;
        i_exp_greater = bt.e;
        i_diff_value  = bt.d;
        i_diff_signal = bt.s;
        i_ready       = r;
        @(negedge clk);
        last_ov = o_valid;
        acc     = 1'b0;
        if (hold) begin
            check("hold_valid", o_valid, 1);
            check("hold_large", o_man_large, h_large);
            check("hold_small", o_man_small, h_small);
            check("hold_exp", o_exp, h_exp);
            check("hold_swap", o_swap, h_swap);
        end
        if (q.size() == 2 && !i_ready)
            check("full_ready", o_ready, 0);
        if (o_valid && i_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", o_valid, 0);
            end else begin
                x = q.pop_front();
                check("out_large", o_man_large, x.xl);
                check("out_small", o_man_small, x.xs);
                check("out_exp", o_exp, x.e);
                check("out_swap", o_swap, x.s);
            end
        end
        hold    = o_valid && !i_ready;
        h_exp   = o_exp;
        h_swap  = o_swap;
        h_large = o_man_large;
        h_small = o_man_small;
        if (i_valid && o_ready) begin
            q.push_back(bt);
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle   = '0;
        tbl[0] = '{24'hC00000, 24'h800001, 8'd10, 8'd1,   1'b0, 24'hC00000, 27'h2000004};
        tbl[1] = '{24'hC00000, 24'h800001, 8'd11, 8'd2,   1'b0, 24'hC00000, 27'h1000002};
        tbl[2] = '{24'hC00000, 24'h800001, 8'd12, 8'd3,   1'b0, 24'hC00000, 27'h0800001};
        tbl[3] = '{24'hC00000, 24'h800001, 8'd13, 8'd3,   1'b1, 24'h800001, 27'h0C00000};
        tbl[4] = '{24'hC00000, 24'h800001, 8'd14, 8'd30,  1'b0, 24'hC00000, 27'h0000001};
        tbl[5] = '{24'hC00000, 24'h800001, 8'd15, 8'd255, 1'b0, 24'hC00000, 27'h0000001};
        tbl[6] = '{24'hC00000, 24'h000000, 8'd16, 8'd30,  1'b0, 24'hC00000, 27'h0000000};
        tbl[7] = '{24'hC00000, 24'h800001, 8'd17, 8'd0,   1'b0, 24'hC00000, 27'h4000008};
        tbl[8] = '{24'hC00000, 24'h800001, 8'd18, 8'd25,  1'b0, 24'hC00000, 27'h0000003};
        tbl[9] = '{24'hC00000, 24'h800001, 8'd19, 8'd26,  1'b0, 24'hC00000, 27'h0000001};
        hold          = 1'b0;
        rst_n         = 1'b0;
        i_valid       = 1'b1;
        i_man_a       = tbl[0].a;
        i_man_b       = tbl[0].b;
        i_exp_greater = tbl[0].e;
        i_diff_value  = tbl[0].d;
        i_diff_signal = 1'b0;
        i_ready       = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 0);
        check("rst_large", o_man_large, 0);
        check("rst_small", o_man_small, 0);
        check("rst_exp", o_exp, 0);
        check("rst_swap", o_swap, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(1'b1, tbl[0], 1'b1);
        check("lat_accept", acc, 1);
        step(1'b0, idle, 1'b1);
        check("lat_cycle1", last_ov, 0);
        step(1'b0, idle, 1'b1);
        check("lat_cycle2", last_ov, 1);

        for (int i = 1; i < 10; i++) begin
            step(1'b1, tbl[i], 1'b1);
            check("b2b_accept", acc, 1);
        end
        for (int k = 0; k < 20 && q.size() > 0; k++)
            step(1'b0, idle, 1'b1);
        check("b2b_drain", q.size(), 0);

        idx = 0;
        for (int c = 0; c < 200 && (idx < 6 || q.size() > 0); c++) begin
            rdy = (c >= 2 && c <= 5) ? 1'b0 : 1'($urandom_range(0, 1));
            step(idx < 6, (idx < 6) ? tbl[idx] : idle, rdy);
            if (acc) idx++;
        end
        check("bp_sent", idx, 6);
        check("bp_drain", q.size(), 0);

        step(1'b1, tbl[6], 1'b0);
        step(1'b1, tbl[7], 1'b0);
        check("pre_rst_valid", o_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_ready", o_ready, 0);
        check("mid_rst_small", o_man_small, 0);
        q.delete();
        hold    = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, tbl[8], 1'b1);
        check("post_accept", acc, 1);
        step(1'b0, idle, 1'b1);
        check("post_cycle1", last_ov, 0);
        step(1'b0, idle, 1'b1);
        check("post_cycle2", last_ov, 1);
        repeat (3) step(1'b0, idle, 1'b1);
        check("post_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
